// File: rtl/mcu_gpio_bridge.sv
// mcu_gpio_bridge: MCU 8-bit asynchronous parallel bus to banked GPIO register file.
// The MCU strobe is synchronised into the CLK50 domain and handled by a
// RECOVER/IDLE/ACK handshake FSM. Each bank of 8 pins has OUT, DIR, IN
// (synchronised level) and EDGE (rising-edge status, write-1-to-clear) registers.
// PINS_COUNT must be a multiple of 8 (>= 8), and ADDR_W >= 2 + clog2(PINS_COUNT/8).
`timescale 1ns/1ps

module mcu_gpio_bridge #(
  parameter int PINS_COUNT = 128,
  parameter int ADDR_W     = 6
) (
  input  logic                  CLK50,
  input  logic                  rst_n,
  inout  wire  [7:0]            data,
  input  logic [ADDR_W-1:0]     address,
  input  logic                  write_enable,
  input  logic                  mcu_mstr,
  output logic                  fpga_ready,
  output logic                  fpga_ack,
  output logic                  irq,
  inout  wire  [PINS_COUNT-1:0] io_pins
);

  localparam int NB     = PINS_COUNT / 8;
  localparam int BANK_W = ADDR_W - 2;

  localparam logic [1:0] SET_OUT  = 2'd0;
  localparam logic [1:0] SET_DIR  = 2'd1;
  localparam logic [1:0] SET_IN   = 2'd2;
  localparam logic [1:0] SET_EDGE = 2'd3;

  typedef enum logic [1:0] {
    S_RECOVER = 2'd0,
    S_IDLE    = 2'd1,
    S_ACK     = 2'd2
  } state_t;

  state_t state;

  // Strobe synchroniser stages
  logic mstr_p0;
  logic mstr_s;

  // Pin synchroniser stages; in_s_p2 holds the previous in_s for edge detection
  logic [PINS_COUNT-1:0] in_p0;
  logic [PINS_COUNT-1:0] in_s;
  logic [PINS_COUNT-1:0] in_s_p2;

  // Register file
  logic [PINS_COUNT-1:0] out_r;
  logic [PINS_COUNT-1:0] dir_r;
  logic [PINS_COUNT-1:0] edge_r;

  // Bus-side read path
  logic [7:0] rdata;
  logic       drive_data;

  // Address decode and access qualifiers
  logic [1:0]            set_sel;
  logic [BANK_W-1:0]     bank_sel;
  logic [NB-1:0]         bank_hit;
  logic                  accept;
  logic                  wr_stb;
  logic [7:0]            rd_val;
  logic [PINS_COUNT-1:0] w1c_mask;

  assign set_sel  = address[ADDR_W-1:ADDR_W-2];
  assign bank_sel = address[BANK_W-1:0];

  // A transaction is taken exactly once: on the IDLE cycle that first sees mstr_s high
  assign accept = (state == S_IDLE) && mstr_s;
  assign wr_stb = accept && write_enable;

  // One-hot bank decode; an index >= NB matches no bank, so it reads 0 and writes nothing
  always_comb begin
    bank_hit = '0;
    for (int b = 0; b < NB; b++) begin
      bank_hit[b] = (bank_sel == BANK_W'(b));
    end
  end

  // Read mux over the selected set and bank
  always_comb begin
    rd_val = 8'h00;
    for (int b = 0; b < NB; b++) begin
      if (bank_hit[b]) begin
        case (set_sel)
          SET_OUT:  rd_val = out_r[8*b +: 8];
          SET_DIR:  rd_val = dir_r[8*b +: 8];
          SET_IN:   rd_val = in_s[8*b +: 8];
          default:  rd_val = edge_r[8*b +: 8];
        endcase
      end
    end
  end

  // Write-1-to-clear mask for the EDGE set, live only on the capture cycle
  always_comb begin
    w1c_mask = '0;
    for (int b = 0; b < NB; b++) begin
      if (wr_stb && (set_sel == SET_EDGE) && bank_hit[b]) begin
        w1c_mask[8*b +: 8] = data;
      end
    end
  end

  // Two-flop synchronisers for the strobe and every pin. The strobe chain resets
  // high so a strobe still held at reset release is seen as busy, not as new.
  always_ff @(posedge CLK50 or negedge rst_n) begin
    if (!rst_n) begin
      mstr_p0 <= 1'b1;
      mstr_s  <= 1'b1;
      in_p0   <= '0;
      in_s    <= '0;
      in_s_p2 <= '0;
    end else begin
      mstr_p0 <= mcu_mstr;
      mstr_s  <= mstr_p0;
      in_p0   <= io_pins;
      in_s    <= in_p0;
      in_s_p2 <= in_s;
    end
  end

  // OUT and DIR writes; IN is read-only and EDGE is handled by its own register
  always_ff @(posedge CLK50 or negedge rst_n) begin
    if (!rst_n) begin
      out_r <= '0;
      dir_r <= '0;
    end else if (wr_stb) begin
      for (int b = 0; b < NB; b++) begin
        if (bank_hit[b]) begin
          case (set_sel)
            SET_OUT: out_r[8*b +: 8] <= data;
            SET_DIR: dir_r[8*b +: 8] <= data;
            default: ;
          endcase
        end
      end
    end
  end

  // Rising-edge status: a new edge in the same cycle as a W1C clear keeps the bit set
  always_ff @(posedge CLK50 or negedge rst_n) begin
    if (!rst_n) begin
      edge_r <= '0;
    end else begin
      edge_r <= (edge_r & ~w1c_mask) | (in_s & ~in_s_p2);
    end
  end

  // Level interrupt, one register behind the EDGE bits
  always_ff @(posedge CLK50 or negedge rst_n) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else begin
      irq <= |edge_r;
    end
  end

  // Handshake FSM with registered ready/ack/bus-drive outputs
  always_ff @(posedge CLK50 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_RECOVER;
      fpga_ready <= 1'b0;
      fpga_ack   <= 1'b0;
      drive_data <= 1'b0;
      rdata      <= 8'h00;
    end else begin
      case (state)
        S_RECOVER: begin
          if (!mstr_s) begin
            state      <= S_IDLE;
            fpga_ready <= 1'b1;
          end
        end
        S_IDLE: begin
          if (mstr_s) begin
            state      <= S_ACK;
            fpga_ready <= 1'b0;
            fpga_ack   <= 1'b1;
            drive_data <= !write_enable;
            if (!write_enable) begin
              rdata <= rd_val;
            end
          end
        end
        S_ACK: begin
          if (!mstr_s) begin
            state      <= S_IDLE;
            fpga_ready <= 1'b1;
            fpga_ack   <= 1'b0;
            drive_data <= 1'b0;
          end
        end
        default: begin
          state      <= S_RECOVER;
          fpga_ready <= 1'b0;
          fpga_ack   <= 1'b0;
          drive_data <= 1'b0;
        end
      endcase
    end
  end

  assign data = drive_data ? rdata : 8'bz;

  // Per-pin tristate: drive OUT only where DIR is set
  for (genvar i = 0; i < PINS_COUNT; i++) begin : g_pin
    assign io_pins[i] = dir_r[i] ? out_r[i] : 1'bz;
  end

endmodule

// File: tb/tb_mcu_gpio_bridge.sv
// Directed bench for mcu_gpio_bridge with a read scoreboard.
// Released data lines are pulled up (read 0xFF); released pins are pulled down.
`timescale 1ns/1ps

module tb_mcu_gpio_bridge;

  localparam int PINS = 32;
  localparam int AW   = 6;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            mcu_mstr;
  logic            we;
  logic [AW-1:0]   addr;
  logic [7:0]      tb_data;
  logic            tb_data_oe;
  logic [PINS-1:0] tb_pin_val;
  logic [PINS-1:0] tb_pin_oe;
  logic            fpga_ready;
  logic            fpga_ack;
  logic            irq;
  wire  [7:0]      data;
  wire  [PINS-1:0] io_pins;

  int total  = 0;
  int passed = 0;
  int fails  = 0;
  logic [7:0] sb_q[$];

  assign data = tb_data_oe ? tb_data : 8'bz;

  for (genvar gi = 0; gi < 8; gi++) begin : g_dpull
    pullup pu (data[gi]);
  end

  for (genvar gi = 0; gi < PINS; gi++) begin : g_tbpin
    assign io_pins[gi] = tb_pin_oe[gi] ? tb_pin_val[gi] : 1'bz;
    pulldown pd (io_pins[gi]);
  end

  mcu_gpio_bridge #(.PINS_COUNT(PINS), .ADDR_W(AW)) dut (
    .CLK50        (clk),
    .rst_n        (rst_n),
    .data         (data),
    .address      (addr),
    .write_enable (we),
    .mcu_mstr     (mcu_mstr),
    .fpga_ready   (fpga_ready),
    .fpga_ack     (fpga_ack),
    .irq          (irq),
    .io_pins      (io_pins)
  );

  always #10 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!fpga_ack && cyc < 10);
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!fpga_ready && cyc < 10);
  endtask

  task automatic mcu_write(input logic [1:0] set, input logic [3:0] bank,
                           input logic [7:0] val, input string tag, input int rise_pin);
    int cyc;
    addr       = {set, bank};
    we         = 1'b1;
    tb_data    = val;
    tb_data_oe = 1'b1;
    mcu_mstr   = 1'b1;
    if (rise_pin >= 0) tb_pin_val[rise_pin] = 1'b1;
    wait_ack(cyc);
    chk({tag, " ack latency"}, cyc, 3);
    mcu_mstr = 1'b0;
    wait_ready(cyc);
    chk({tag, " release latency"}, cyc, 3);
    tb_data_oe = 1'b0;
  endtask

  task automatic mcu_read(input logic [1:0] set, input logic [3:0] bank,
                          input logic [7:0] exp, input string tag);
    int cyc;
    logic [7:0] e;
    sb_q.push_back(exp);
    addr       = {set, bank};
    we         = 1'b0;
    tb_data_oe = 1'b0;
    mcu_mstr   = 1'b1;
    wait_ack(cyc);
    chk({tag, " ack latency"}, cyc, 3);
    e = sb_q.pop_front();
    chk({tag, " data"}, data, e);
    mcu_mstr = 1'b0;
    wait_ready(cyc);
    chk({tag, " bus released"}, data, 8'hFF);
  endtask

  initial begin
    int cyc;
    int bad;
    logic [7:0] e;

    rst_n      = 1'b0;
    mcu_mstr   = 1'b1;
    we         = 1'b0;
    addr       = '0;
    tb_data    = 8'h00;
    tb_data_oe = 1'b0;
    tb_pin_val = '0;
    tb_pin_oe  = '0;

    // Reset with strobe held high
    repeat (3) tick();
    chk("reset ready", fpga_ready, 0);
    chk("reset ack", fpga_ack, 0);
    chk("reset irq", irq, 0);
    chk("reset data z", data, 8'hFF);
    chk("reset pins z", io_pins, 32'h0);
    rst_n = 1'b1;
    repeat (6) tick();
    chk("held strobe ready", fpga_ready, 0);
    chk("held strobe ack", fpga_ack, 0);
    chk("held strobe data z", data, 8'hFF);
    mcu_mstr = 1'b0;
    wait_ready(cyc);
    chk("ready after strobe drop", (cyc <= 3), 1);

    // DIR/OUT write-back on bank 2
    mcu_write(2'd1, 4'd2, 8'hFF, "dir b2 wr", -1);
    mcu_write(2'd0, 4'd2, 8'hA5, "out b2 wr", -1);
    chk("pins b2", io_pins[23:16], 8'hA5);
    chk("pins b1 z", io_pins[15:8], 8'h00);
    mcu_read(2'd2, 4'd2, 8'hA5, "in b2");
    mcu_read(2'd0, 4'd2, 8'hA5, "out b2");
    mcu_read(2'd1, 4'd2, 8'hFF, "dir b2");
    mcu_read(2'd3, 4'd2, 8'hA5, "edge b2 own drive");
    chk("irq from own drive", irq, 1);
    mcu_write(2'd3, 4'd2, 8'hA5, "edge b2 clr", -1);
    chk("irq after b2 clr", irq, 0);

    // Input rising edge on pin 5
    tb_pin_oe[5] = 1'b1;
    tb_pin_oe[3] = 1'b1;
    repeat (4) tick();
    tb_pin_val[5] = 1'b1;
    repeat (3) tick();
    chk("irq 3 clk after pin", irq, 0);
    tick();
    chk("irq 4 clk after pin", irq, 1);
    mcu_read(2'd3, 4'd0, 8'h20, "edge b0 pin5");
    mcu_write(2'd3, 4'd0, 8'h20, "edge b0 clr", -1);
    chk("irq after pin5 clr", irq, 0);
    mcu_read(2'd3, 4'd0, 8'h00, "edge b0 cleared");

    // W1C on EDGE[3] coinciding with a new rise on pin 3
    mcu_write(2'd3, 4'd0, 8'h08, "w1c vs set", 3);
    mcu_read(2'd3, 4'd0, 8'h08, "edge3 set wins");
    chk("irq set wins", irq, 1);
    mcu_write(2'd3, 4'd0, 8'h08, "edge3 clr", -1);
    mcu_read(2'd3, 4'd0, 8'h00, "edge3 cleared");
    chk("irq edge3 clr", irq, 0);

    // Out-of-range bank and read-only IN
    mcu_write(2'd0, 4'd4, 8'hFF, "oob wr", -1);
    mcu_read(2'd0, 4'd4, 8'h00, "oob out rd");
    mcu_read(2'd1, 4'd4, 8'h00, "oob dir rd");
    mcu_read(2'd0, 4'd0, 8'h00, "out b0 after oob");
    mcu_read(2'd0, 4'd2, 8'hA5, "out b2 after oob");
    mcu_write(2'd2, 4'd2, 8'h5A, "in wr", -1);
    mcu_read(2'd2, 4'd2, 8'hA5, "in b2 after wr");
    mcu_read(2'd0, 4'd2, 8'hA5, "out b2 after in wr");
    mcu_read(2'd1, 4'd2, 8'hFF, "dir b2 after in wr");

    // 20-clock strobe: a new pin-3 edge during the hold must survive
    tb_pin_val[3] = 1'b0;
    repeat (4) tick();
    addr       = {2'd3, 4'd0};
    we         = 1'b1;
    tb_data    = 8'h08;
    tb_data_oe = 1'b1;
    mcu_mstr   = 1'b1;
    wait_ack(cyc);
    chk("long strobe ack latency", cyc, 3);
    tb_pin_val[3] = 1'b1;
    bad = 0;
    repeat (17) begin
      tick();
      if (!fpga_ack || fpga_ready) bad++;
    end
    chk("long strobe ack held", bad, 0);
    mcu_mstr = 1'b0;
    wait_ready(cyc);
    tb_data_oe = 1'b0;
    mcu_read(2'd3, 4'd0, 8'h08, "long strobe single write");
    mcu_write(2'd3, 4'd0, 8'h08, "long edge clr", -1);

    // Reset asserted during a read ACK
    sb_q.push_back(8'hA5);
    addr     = {2'd0, 4'd2};
    we       = 1'b0;
    mcu_mstr = 1'b1;
    wait_ack(cyc);
    chk("mid-ack ack latency", cyc, 3);
    e = sb_q.pop_front();
    chk("mid-ack data", data, e);
    chk("mid-ack pins b2", io_pins[23:16], 8'hA5);
    rst_n = 1'b0;
    #1;
    chk("reset in ack: ack", fpga_ack, 0);
    chk("reset in ack: data z", data, 8'hFF);
    chk("reset in ack: pins z", io_pins[23:16], 8'h00);
    chk("reset in ack: ready", fpga_ready, 0);
    mcu_mstr = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    wait_ready(cyc);
    chk("ready after mid-ack reset", (cyc <= 3), 1);
    mcu_read(2'd0, 4'd2, 8'h00, "out b2 after reset");
    mcu_read(2'd1, 4'd2, 8'h00, "dir b2 after reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mcu_gpio_bridge.md
# mcu_gpio_bridge

Parametrised successor to the fixed 128-pin MCU/FPGA bridge. It terminates the MCU 8-bit asynchronous parallel bus with a synchronised strobe/ack handshake. Behind that bus it exposes a banked register file with per-pin output, direction, synchronised input and rising-edge status. It drives the FPGA `io_pins` tristates directly and raises a level interrupt on latched edges. It sits at the top level between the MCU bus pins and the user I/O pins.

## Interface
- PINS_COUNT, 128: number of I/O pins; must be a multiple of 8 and at least 8.
- ADDR_W, 6: MCU address width; must satisfy ADDR_W >= 2 + clog2(PINS_COUNT/8).
- CLK50  in  1: system clock, 50 MHz.
- rst_n  in  1: reset, asynchronous assert, active-low. Deasserts synchronously to CLK50 via an external reset synchroniser.
- data  inout  8: MCU data bus. Driven by the bridge only during a read acknowledge, otherwise high-Z.
- address  in  ADDR_W: register address. Bits [ADDR_W-1:ADDR_W-2] are the set; the low bits are the bank.
- write_enable  in  1: 1 = write, 0 = read; qualified by mcu_mstr.
- mcu_mstr  in  1: MCU transaction strobe, asynchronous to CLK50.
- fpga_ready  out  1: bridge idle and able to accept a strobe.
- fpga_ack  out  1: transaction complete. For reads, data is valid while this is high.
- irq  out  1: OR of all edge-status bits.
- io_pins  inout  PINS_COUNT: user pins.

## Operation
- Banks: NB = PINS_COUNT/8. Bank b covers pins [8b+7:8b].
- Register sets, selected by address[ADDR_W-1:ADDR_W-2]:
  - 0 OUT: read/write output value.
  - 1 DIR: read/write; 1 = pin drives.
  - 2 IN: read-only synchronised pin level. Writes are ignored.
  - 3 EDGE: rising-edge status, write-1-to-clear.
- Bank index >= NB: writes ignored, reads return 0x00.
- Pin i = OUT[i] when DIR[i]=1, else Z.
- Every pin passes through a 2-flop synchroniser into in_s; an IN read returns in_s.
- EDGE[i] sets when in_s[i] is 1 and its previous value was 0. This applies regardless of DIR.
- EDGE set and W1C clear in the same cycle: the set wins and the bit stays 1.
- irq = |EDGE, registered.
- mcu_mstr passes through a 2-flop synchroniser to give mstr_s. address, write_enable and data are sampled unsynchronised at capture. The bus protocol holds them stable from before the strobe rises until fpga_ack is seen.
- FSM:
  - RECOVER (entered at reset): fpga_ready=0. Goes to IDLE when mstr_s=0.
  - IDLE: fpga_ready=1. On mstr_s=1: capture address and write_enable; perform the write or load the read register into rdata; go to ACK.
  - ACK: fpga_ack=1, fpga_ready=0. For a read, data = rdata. On mstr_s=0 go to IDLE; the data bus is released in that same cycle.
- Exactly one register access per strobe, however long the strobe is held.
- Reset values: OUT, DIR, EDGE, in_s and rdata are all 0. fpga_ready=0, fpga_ack=0, irq=0, data = Z, io_pins all Z. FSM = RECOVER.
- Reset asserted mid-transaction: everything returns to reset values immediately, asynchronously.
  - A strobe still high after reset release is not executed. The FSM waits in RECOVER for it to fall.

## Timing
- The mcu_mstr rise is first sampled at edge N. mstr_s is high after N+1.
- At edge N+2 the FSM captures the transaction and performs the write.
- fpga_ack and the read data are valid after N+2, giving a latency of 3 clocks (60 ns).
- A written OUT/DIR value reaches io_pins after edge N+2.
- The mcu_mstr fall, first sampled at edge M, drops fpga_ack and releases data after M+2. fpga_ready rises in the same cycle.
- Pin edge to EDGE bit: 3 clocks (2 synchroniser flops plus the detect register). EDGE to irq: 1 further clock.
- Minimum transaction spacing: 6 clocks from strobe rise to the next accepted strobe rise.

## Test plan
- **Reset release with mcu_mstr held high:**
  - While the strobe is high: no ack, fpga_ready=0, data = Z.
  - After the strobe drops: fpga_ready=1 within 3 clocks.
- **DIR/OUT write-back:** write DIR bank 2 = 0xFF, then OUT bank 2 = 0xA5.
  - io_pins[23:16] = 0xA5.
  - Reading IN bank 2 returns 0xA5.
  - Reading OUT bank 2 returns 0xA5.
  - fpga_ack rises 3 clocks after each strobe.
- **Input and edge:** with DIR=0, drive io_pins[5] 0→1.
  - EDGE bank 0 reads 0x20.
  - irq=1 four clocks after the pin rises.
  - Writing 0x20 to EDGE bank 0 clears it and irq returns to 0.
- **Simultaneous set and clear:** issue a W1C on EDGE[3] in the same cycle as a new rising edge on pin 3.
  - EDGE[3] stays 1.
- **Out of range and read-only accesses:**
  - Write 0xFF to bank NB of set 0: no register changes.
  - Read from that bank returns 0x00.
  - Write to IN is ignored.
- **Long strobe and mid-ack reset:**
  - A strobe held for 20 clocks performs a single write.
  - Asserting rst_n=0 during ACK clears fpga_ack and releases data and io_pins to Z in the same cycle.
